// File: rtl/pipe_pkg.sv
// Shared pipeline constants, result/load selectors and the MEM/WB payload type.
package pipe_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned NREG      = 32;
    localparam int unsigned PEND_W    = 2;

    typedef enum logic [1:0] {
        WSEL_ALU  = 2'd0,
        WSEL_LOAD = 2'd1,
        WSEL_PC4  = 2'd2,
        WSEL_RSV  = 2'd3
    } wsel_e;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } funct3_e;

    typedef struct packed {
        logic                 w_en;
        logic [REG_IDX_W-1:0] rd;
        logic [XLEN-1:0]      data;
    } wb_t;

endpackage

// File: rtl/load_align.sv
// Byte/half extraction and sign/zero extension of an aligned load word.
module load_align
    import pipe_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] data,
    output logic [XLEN-1:0] res
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = data[7:0];
        case (addr_lo)
            2'd1:    byte_v = data[15:8];
            2'd2:    byte_v = data[23:16];
            2'd3:    byte_v = data[31:24];
            default: byte_v = data[7:0];
        endcase
        half_v = addr_lo[1] ? data[31:16] : data[15:0];
    end

    // Unknown load types fall through to the raw word.
    always_comb begin
        res = data;
        case (funct3)
            F3_LB:   res = {{(XLEN-8){byte_v[7]}}, byte_v};
            F3_LH:   res = {{(XLEN-16){half_v[15]}}, half_v};
            F3_LBU:  res = {{(XLEN-8){1'b0}}, byte_v};
            F3_LHU:  res = {{(XLEN-16){1'b0}}, half_v};
            default: res = data;
        endcase
    end

endmodule

// File: rtl/reg_writeback_ctrl.sv
// MEM/WB register, result formatting and pending-write scoreboard feeding
// decode's hazard/bypass logic.
module reg_writeback_ctrl
    import pipe_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 iss_valid,
    input  logic                 iss_wen,
    input  logic [REG_IDX_W-1:0] iss_rd,
    output logic                 iss_ready,
    input  logic                 mem_valid,
    input  logic                 mem_wen,
    input  logic [REG_IDX_W-1:0] mem_rd,
    input  logic [1:0]           mem_wsel,
    input  logic [2:0]           mem_funct3,
    input  logic [1:0]           mem_addr_lo,
    input  logic [XLEN-1:0]      mem_alu_res,
    input  logic [XLEN-1:0]      mem_load_data,
    input  logic [XLEN-1:0]      mem_pc4,
    input  logic [REG_IDX_W-1:0] rs1,
    input  logic [REG_IDX_W-1:0] rs2,
    output logic                 haz_rs1,
    output logic                 haz_rs2,
    output logic                 fwd_rs1,
    output logic                 fwd_rs2,
    output logic [XLEN-1:0]      fwd_data,
    output logic [REG_IDX_W-1:0] rd,
    output logic                 w_en,
    output logic [XLEN-1:0]      d_in
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    logic [XLEN-1:0]   load_res;
    logic [XLEN-1:0]   wb_data_c;
    wb_t               wb_q;
    logic [PEND_W-1:0] pend [NREG];
    logic [NREG-1:0]   inc_vec;
    logic [NREG-1:0]   dec_vec;

    load_align u_load_align (
        .funct3  (mem_funct3),
        .addr_lo (mem_addr_lo),
        .data    (mem_load_data),
        .res     (load_res)
    );

    always_comb begin
        wb_data_c = mem_alu_res;
        case (mem_wsel)
            WSEL_LOAD: wb_data_c = load_res;
            WSEL_PC4:  wb_data_c = mem_pc4;
            default:   wb_data_c = mem_alu_res;
        endcase
    end

    // MEM/WB register; rd and data hold across bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_q <= '0;
        end else if (mem_valid) begin
            wb_q.w_en <= mem_wen && (mem_rd != '0);
            wb_q.rd   <= mem_rd;
            wb_q.data <= wb_data_c;
        end else begin
            wb_q.w_en <= 1'b0;
        end
    end

    assign w_en     = wb_q.w_en;
    assign rd       = wb_q.rd;
    assign d_in     = wb_q.data;
    assign fwd_data = wb_q.data;

    // The committing write frees its slot in the same cycle, so a full counter can still accept.
    always_comb begin
        dec_vec = '0;
        if (wb_q.w_en) dec_vec[wb_q.rd] = 1'b1;
    end

    assign iss_ready = !(iss_wen && (iss_rd != '0) && (pend[iss_rd] == PEND_MAX))
                       || dec_vec[iss_rd];

    always_comb begin
        inc_vec = '0;
        if (iss_valid && iss_ready && iss_wen && (iss_rd != '0)) inc_vec[iss_rd] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) pend[r] <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (inc_vec[r] && !dec_vec[r]) begin
                    pend[r] <= pend[r] + PEND_W'(1);
                end else if (dec_vec[r] && !inc_vec[r] && (pend[r] != '0)) begin
                    pend[r] <= pend[r] - PEND_W'(1);
                end
            end
        end
    end

    assign fwd_rs1 = wb_q.w_en && (wb_q.rd == rs1) && (rs1 != '0);
    assign fwd_rs2 = wb_q.w_en && (wb_q.rd == rs2) && (rs2 != '0);
    assign haz_rs1 = (pend[rs1] - PEND_W'(fwd_rs1)) != '0;
    assign haz_rs2 = (pend[rs2] - PEND_W'(fwd_rs2)) != '0;

    a_no_underflow: assert property (
        @(posedge clk) disable iff (!rst_n) wb_q.w_en |-> (pend[wb_q.rd] != '0)
    );

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Directed and randomized checks of reg_writeback_ctrl against a counting reference model.
module tb_reg_writeback_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        iss_valid, iss_wen, mem_valid, mem_wen;
    logic [4:0]  iss_rd, mem_rd, rs1, rs2;
    logic [1:0]  mem_wsel, mem_addr_lo;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_alu_res, mem_load_data, mem_pc4;
    logic        iss_ready, haz_rs1, haz_rs2, fwd_rs1, fwd_rs2, w_en;
    logic [31:0] fwd_data, d_in;
    logic [4:0]  rd;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: outstanding-write counts and the value sitting in write-back.
    int          pend_m [32];
    bit          m_wen;
    logic [4:0]  m_rd;
    logic [31:0] m_data;

    reg_writeback_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .iss_valid(iss_valid), .iss_wen(iss_wen), .iss_rd(iss_rd), .iss_ready(iss_ready),
        .mem_valid(mem_valid), .mem_wen(mem_wen), .mem_rd(mem_rd), .mem_wsel(mem_wsel),
        .mem_funct3(mem_funct3), .mem_addr_lo(mem_addr_lo), .mem_alu_res(mem_alu_res),
        .mem_load_data(mem_load_data), .mem_pc4(mem_pc4),
        .rs1(rs1), .rs2(rs2), .haz_rs1(haz_rs1), .haz_rs2(haz_rs2),
        .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2), .fwd_data(fwd_data),
        .rd(rd), .w_en(w_en), .d_in(d_in)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [31:0] fmt_m(input logic [1:0] ws, input logic [2:0] f3,
                                          input logic [1:0] a, input logic [31:0] alu,
                                          input logic [31:0] ld, input logic [31:0] pc4);
        logic [31:0] b, h;
        if (ws == 2'd2) return pc4;
        if (ws != 2'd1) return alu;
        b = (ld >> (8 * 32'(a))) & 32'h0000_00FF;
        h = (ld >> (16 * 32'(a[1]))) & 32'h0000_FFFF;
        case (f3)
            3'b000:  return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
            3'b001:  return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return ld;
        endcase
    endfunction

    function automatic bit ready_m();
        return !(iss_wen && iss_rd != 5'd0 && pend_m[iss_rd] == 3) || (m_wen && m_rd == iss_rd);
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) pend_m[r] = 0;
        m_wen = 1'b0;
        m_rd = 5'd0;
        m_data = 32'd0;
    endtask

    task automatic idle();
        iss_valid = 0; iss_wen = 0; iss_rd = 0;
        mem_valid = 0; mem_wen = 0; mem_rd = 0; mem_wsel = 0; mem_funct3 = 0; mem_addr_lo = 0;
        mem_alu_res = 0; mem_load_data = 0; mem_pc4 = 0; rs1 = 0; rs2 = 0;
    endtask

    // Advance one clock edge, updating the model from the inputs presented before it.
    task automatic cycle();
        bit rdy, inc;
        rdy = ready_m();
        inc = iss_valid && rdy && iss_wen && iss_rd != 5'd0;
        if (inc) pend_m[iss_rd]++;
        if (m_wen && pend_m[m_rd] > 0) pend_m[m_rd]--;
        if (mem_valid) begin
            m_wen  = mem_wen && mem_rd != 5'd0;
            m_rd   = mem_rd;
            m_data = fmt_m(mem_wsel, mem_funct3, mem_addr_lo, mem_alu_res, mem_load_data, mem_pc4);
        end else begin
            m_wen = 1'b0;
        end
        @(posedge clk);
        #1;
        iss_valid = 0;
        mem_valid = 0;
    endtask

    task automatic issue(input logic [4:0] r);
        iss_valid = 1; iss_wen = 1; iss_rd = r;
    endtask

    task automatic retire(input logic [4:0] r, input logic wen, input logic [1:0] ws,
                          input logic [2:0] f3, input logic [1:0] a, input logic [31:0] alu,
                          input logic [31:0] ld, input logic [31:0] pc4);
        mem_valid = 1; mem_wen = wen; mem_rd = r; mem_wsel = ws; mem_funct3 = f3;
        mem_addr_lo = a; mem_alu_res = alu; mem_load_data = ld; mem_pc4 = pc4;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        model_reset();
        iss_wen = 1; iss_rd = 5'd5; rs1 = 5'd5; rs2 = 5'd5;
        #12;
        n_cmp++; if (w_en !== 1'b0) begin n_err++; $display("FAIL reset_w_en: got %b want 0", w_en); end
        n_cmp++; if (rd !== 5'd0) begin n_err++; $display("FAIL reset_rd: got %0d want 0", rd); end
        n_cmp++; if (d_in !== 32'd0) begin n_err++; $display("FAIL reset_d_in: got %h want 0", d_in); end
        n_cmp++; if (iss_ready !== 1'b1) begin n_err++; $display("FAIL reset_iss_ready: got %b want 1", iss_ready); end
        n_cmp++; if ({haz_rs1, haz_rs2, fwd_rs1, fwd_rs2} !== 4'b0) begin
            n_err++; $display("FAIL reset_flags: got %b want 0000", {haz_rs1, haz_rs2, fwd_rs1, fwd_rs2}); end
        rst_n = 1;
        idle();
        @(posedge clk); #1;
        // Reset in the middle of a write-back cycle.
        issue(5'd4); cycle();
        retire(5'd4, 1, 2'd0, 3'd0, 2'd0, 32'hAAAA_5555, 32'd0, 32'd0); cycle();
        n_cmp++; if (w_en !== 1'b1) begin n_err++; $display("FAIL pre_reset_w_en: got %b want 1", w_en); end
        #2; rst_n = 0; rs1 = 5'd4; #1;
        n_cmp++; if (w_en !== 1'b0) begin n_err++; $display("FAIL midreset_w_en: got %b want 0", w_en); end
        n_cmp++; if (rd !== 5'd0) begin n_err++; $display("FAIL midreset_rd: got %0d want 0", rd); end
        n_cmp++; if (d_in !== 32'd0) begin n_err++; $display("FAIL midreset_d_in: got %h want 0", d_in); end
        n_cmp++; if (haz_rs1 !== 1'b0) begin n_err++; $display("FAIL midreset_haz: got %b want 0", haz_rs1); end
        model_reset();
        #1; rst_n = 1;
        issue(5'd5); cycle();
        rs1 = 5'd5; #1;
        n_cmp++; if (haz_rs1 !== 1'b1) begin n_err++; $display("FAIL post_reset_haz_rs1: got %b want 1", haz_rs1); end
        n_cmp++; if (fwd_rs1 !== 1'b0) begin n_err++; $display("FAIL post_reset_fwd_rs1: got %b want 0", fwd_rs1); end
    endtask

    task automatic test_load_format();
        logic [2:0]  f3_t [4]  = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [1:0]  a_t  [4]  = '{2'd0, 2'd2, 2'd2, 2'd0};
        logic [31:0] e_t  [4]  = '{32'hFFFF_FFF7, 32'h0000_0081, 32'hFFFF_8081, 32'h0000_F0F7};
        for (int i = 0; i < 4; i++) begin
            retire(5'd3, 0, 2'd1, f3_t[i], a_t[i], 32'h1111_1111, 32'h8081_F0F7, 32'h2222_2222);
            cycle();
            n_cmp++; if (d_in !== e_t[i]) begin
                n_err++; $display("FAIL load_fmt_%0d: got %h want %h", i, d_in, e_t[i]); end
            n_cmp++; if (w_en !== 1'b0) begin
                n_err++; $display("FAIL load_fmt_wen_%0d: got %b want 0", i, w_en); end
        end
    endtask

    task automatic test_x0();
        issue(5'd0); #1;
        n_cmp++; if (iss_ready !== 1'b1) begin n_err++; $display("FAIL x0_iss_ready: got %b want 1", iss_ready); end
        cycle();
        retire(5'd0, 1, 2'd0, 3'd0, 2'd0, 32'h0000_1234, 32'd0, 32'd0); cycle();
        rs1 = 5'd0; #1;
        n_cmp++; if (w_en !== 1'b0) begin n_err++; $display("FAIL x0_w_en: got %b want 0", w_en); end
        n_cmp++; if (d_in !== 32'h0000_1234) begin n_err++; $display("FAIL x0_d_in: got %h want 00001234", d_in); end
        n_cmp++; if (haz_rs1 !== 1'b0) begin n_err++; $display("FAIL x0_haz: got %b want 0", haz_rs1); end
        n_cmp++; if (fwd_rs1 !== 1'b0) begin n_err++; $display("FAIL x0_fwd: got %b want 0", fwd_rs1); end
    endtask

    task automatic test_forward();
        issue(5'd7); cycle();
        rs2 = 5'd7; #1;
        n_cmp++; if (haz_rs2 !== 1'b1) begin n_err++; $display("FAIL fwd_pending_haz: got %b want 1", haz_rs2); end
        retire(5'd7, 1, 2'd0, 3'd0, 2'd0, 32'hDEAD_BEEF, 32'd0, 32'd0); cycle();
        #1;
        n_cmp++; if (fwd_rs2 !== 1'b1) begin n_err++; $display("FAIL fwd_wb_fwd: got %b want 1", fwd_rs2); end
        n_cmp++; if (haz_rs2 !== 1'b0) begin n_err++; $display("FAIL fwd_wb_haz: got %b want 0", haz_rs2); end
        n_cmp++; if (fwd_data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL fwd_data: got %h want deadbeef", fwd_data); end
        cycle(); #1;
        n_cmp++; if ({fwd_rs2, haz_rs2} !== 2'b00) begin
            n_err++; $display("FAIL fwd_after: got %b want 00", {fwd_rs2, haz_rs2}); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 3; i++) begin issue(5'd9); cycle(); end
        issue(5'd9); #1;
        n_cmp++; if (iss_ready !== 1'b0) begin n_err++; $display("FAIL sat_full_ready: got %b want 0", iss_ready); end
        cycle();
        retire(5'd9, 1, 2'd0, 3'd0, 2'd0, 32'h0000_0009, 32'd0, 32'd0); cycle();
        issue(5'd9); #1;
        n_cmp++; if (iss_ready !== 1'b1) begin n_err++; $display("FAIL sat_wb_ready: got %b want 1", iss_ready); end
        cycle();
        issue(5'd9); rs1 = 5'd9; #1;
        n_cmp++; if (iss_ready !== 1'b0) begin n_err++; $display("FAIL sat_still_full: got %b want 0", iss_ready); end
        n_cmp++; if (haz_rs1 !== 1'b1) begin n_err++; $display("FAIL sat_haz: got %b want 1", haz_rs1); end
        iss_valid = 0;
        for (int i = 0; i < 3; i++) begin
            retire(5'd9, 1, 2'd0, 3'd0, 2'd0, 32'(i), 32'd0, 32'd0); cycle();
        end
        rs1 = 5'd9; #1;
        n_cmp++; if ({haz_rs1, fwd_rs1} !== 2'b01) begin
            n_err++; $display("FAIL sat_last_wb: got haz/fwd %b want 01", {haz_rs1, fwd_rs1}); end
        cycle(); #1;
        n_cmp++; if (haz_rs1 !== 1'b0) begin n_err++; $display("FAIL sat_drained: got %b want 0", haz_rs1); end
    endtask

    task automatic test_pc4();
        issue(5'd1); cycle();
        retire(5'd1, 1, 2'd2, 3'd0, 2'd0, 32'h5555_5555, 32'h6666_6666, 32'h0000_0104); cycle();
        n_cmp++; if (w_en !== 1'b1) begin n_err++; $display("FAIL pc4_w_en: got %b want 1", w_en); end
        n_cmp++; if (rd !== 5'd1) begin n_err++; $display("FAIL pc4_rd: got %0d want 1", rd); end
        n_cmp++; if (d_in !== 32'h0000_0104) begin n_err++; $display("FAIL pc4_d_in: got %h want 00000104", d_in); end
        cycle();
    endtask

    task automatic test_random();
        int  avail;
        bit  e_fwd1, e_fwd2, e_haz1, e_haz2;
        idle();
        rst_n = 0; #2; model_reset(); rst_n = 1;
        @(posedge clk); #1;
        for (int n = 0; n < 400; n++) begin
            iss_valid = 1'($urandom_range(0, 1));
            iss_wen   = 1'($urandom_range(0, 3) != 0);
            iss_rd    = 5'($urandom_range(0, 7));
            mem_valid = 1'($urandom_range(0, 1));
            mem_rd    = 5'($urandom_range(0, 7));
            mem_wen   = 1'($urandom_range(0, 1));
            avail = pend_m[mem_rd] - ((m_wen && m_rd == mem_rd) ? 1 : 0);
            if (mem_rd != 5'd0 && avail <= 0) mem_wen = 0;
            mem_wsel      = 2'($urandom_range(0, 3));
            mem_funct3    = 3'($urandom_range(0, 7));
            mem_addr_lo   = 2'($urandom_range(0, 3));
            mem_alu_res   = $urandom;
            mem_load_data = $urandom;
            mem_pc4       = $urandom;
            rs1 = 5'($urandom_range(0, 7));
            rs2 = 5'($urandom_range(0, 7));
            #1;
            e_fwd1 = m_wen && m_rd == rs1 && rs1 != 5'd0;
            e_fwd2 = m_wen && m_rd == rs2 && rs2 != 5'd0;
            e_haz1 = (pend_m[rs1] - int'(e_fwd1)) != 0;
            e_haz2 = (pend_m[rs2] - int'(e_fwd2)) != 0;
            n_cmp++; if (iss_ready !== ready_m()) begin
                n_err++; $display("FAIL rnd_iss_ready@%0d: got %b want %b", n, iss_ready, ready_m()); end
            n_cmp++; if ({haz_rs1, haz_rs2} !== {e_haz1, e_haz2}) begin
                n_err++; $display("FAIL rnd_haz@%0d: got %b want %b", n, {haz_rs1, haz_rs2}, {e_haz1, e_haz2}); end
            n_cmp++; if ({fwd_rs1, fwd_rs2} !== {e_fwd1, e_fwd2}) begin
                n_err++; $display("FAIL rnd_fwd@%0d: got %b want %b", n, {fwd_rs1, fwd_rs2}, {e_fwd1, e_fwd2}); end
            n_cmp++; if ({w_en, rd} !== {m_wen, m_rd}) begin
                n_err++; $display("FAIL rnd_wport@%0d: got w_en=%b rd=%0d want w_en=%b rd=%0d", n, w_en, rd, m_wen, m_rd); end
            n_cmp++; if (d_in !== m_data || fwd_data !== m_data) begin
                n_err++; $display("FAIL rnd_data@%0d: got d_in=%h fwd_data=%h want %h", n, d_in, fwd_data, m_data); end
            cycle();
        end
    endtask

    initial begin
        test_reset();
        test_load_format();
        test_x0();
        test_forward();
        test_saturation();
        test_pc4();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
